pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 16, range 2..255: max consecutive data-memory wait cycles before halt.
REQ-002 SHALL have parameter CNT_W, default 32: performance counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port id_use_rs2  input  1  ID instruction reads rs2.
REQ-007 SHALL have ports ex_rd  input  5, and ex_memread  input  1: destination and load flag of the instruction in EX.
REQ-008 SHALL have port mem_branch_taken  input  1  branch resolved taken in MEM.
REQ-009 SHALL have ports dmem_req  input  1, and dmem_ready  input  1: data-memory request and ready handshake.
REQ-010 SHALL have outputs pc_write, ifid_write, idex_write, exmem_write, memwb_write  1 each: stage-register load enables.
REQ-011 SHALL have outputs ifid_flush, idex_flush, exmem_flush  1 each: load a bubble (all control bits zero).
REQ-012 SHALL have outputs halted  1, and state  2  (RUN=0, MEM_WAIT=1, HALT=2).

Function
REQ-013 State and wait_cnt (8 bit) SHALL be registered; all control outputs SHALL be combinational from state and current inputs.
REQ-014 Evaluation priority SHALL be: HALT > memory stall > branch flush > load-use stall > normal.
REQ-015 Normal: all *_write=1, all flushes=0.
REQ-016 Memory stall (dmem_req & !dmem_ready, in RUN or MEM_WAIT): all *_write=0, all flushes=0; next state MEM_WAIT.
REQ-017 Entering MEM_WAIT from RUN SHALL set wait_cnt=1; each further unready cycle SHALL increment it.
REQ-018 In MEM_WAIT with wait_cnt==WAIT_MAX and still not ready, next state SHALL be HALT.
REQ-019 In MEM_WAIT with dmem_ready=1: outputs evaluated as in RUN for branch/load-use/normal that cycle; next state RUN; wait_cnt=0.
REQ-020 Branch flush: pc_write=1, all other *_write=1, ifid_flush=idex_flush=exmem_flush=1; load-use detection ignored that cycle.
REQ-021 Load-use hazard = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_use_rs2 & ex_rd==id_rs2)).
REQ-022 Load-use stall: pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1, memwb_write=1; lasts exactly one cycle per hazard.
REQ-023 A flush SHALL never be asserted while its stage write enable is 0.
REQ-024 HALT: all *_write=0, all flushes=0, halted=1; exit only via reset.
REQ-025 dmem_req=0 with dmem_ready=0 SHALL NOT stall.

Reset
REQ-026 Reset low SHALL immediately force state=RUN, wait_cnt=0, halted=0, counters=0, independent of clk.
REQ-027 During reset, outputs SHALL be normal-mode values (writes 1, flushes 0); reset mid-MEM_WAIT or in HALT returns to RUN.

Configuration
REQ-028 Macro PIPE_PERF_CNT_EN defined: outputs stall_cycles and flush_events (CNT_W each) SHALL exist.
REQ-029 stall_cycles SHALL increment each cycle pc_write==0 outside HALT; flush_events SHALL increment each branch-flush cycle; both saturate at all-ones.
REQ-030 Macro undefined: counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-031 ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1; then normal.
REQ-032 ex_memread=1, ex_rd=0, id_rs1=0 -> no stall.
REQ-033 dmem_req=1, dmem_ready low 3 cycles then high -> writes 0 for 3 cycles, state=1, then RUN, wait_cnt=0.
REQ-034 WAIT_MAX=4, dmem_ready held low -> HALT after 5th cycle, halted=1 until reset low.
REQ-035 mem_branch_taken=1 with load-use hazard present -> three flushes=1, pc_write=1, no stall; with PIPE_PERF_CNT_EN flush_events increments by 1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush controller for a 5-stage in-order pipeline.
//            It arbitrates four conditions, from highest to lowest priority:
//            halt, data-memory wait, taken-branch flush, load-use stall.
//            It drives the stage-register load enables and bubble inserts.
//            A data-memory wait that runs too long moves the controller to a
//            sticky HALT state. Only reset leaves HALT.
//
// Parameters
//   WAIT_MAX  : max consecutive data-memory wait cycles before halting (2..255)
//   CNT_W     : width of the optional performance counters
//
// Ports
//   clk                 : sole clock, rising edge
//   reset               : asynchronous, active-low reset
//   id_rs1, id_rs2      : source registers of the instruction in ID
//   id_use_rs2          : ID instruction actually reads rs2
//   ex_rd, ex_memread   : destination / load flag of the instruction in EX
//   mem_branch_taken    : branch resolved taken in MEM
//   dmem_req, dmem_ready: data-memory request / ready handshake
//   pc_write .. memwb_write            : stage-register load enables
//   ifid_flush, idex_flush, exmem_flush : load a bubble into that register
//   halted              : controller is in HALT
//   state               : RUN=0, MEM_WAIT=1, HALT=2
//   stall_cycles, flush_events : performance counters (optional)
//
// Configuration
//   PIPE_PERF_CNT_EN : when defined, adds the saturating stall_cycles and
//                      flush_events counters and their output ports.
//
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             mem_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halted,
   output logic [1:0]       state
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
`endif
);

   localparam logic [1:0] c_RUN      = 2'd0;
   localparam logic [1:0] c_MEM_WAIT = 2'd1;
   localparam logic [1:0] c_HALT     = 2'd2;

   localparam logic [7:0] c_WAIT_MAX = 8'(WAIT_MAX);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_nxt;

   // Set for the cycle after a load-use stall. The stall turns the EX slot
   // into a bubble, so the same ID/EX pair cannot hazard twice. Masking the
   // detector here keeps each hazard to exactly one stall cycle.
   logic       r_lu_done;
   logic       w_lu_done_nxt;

   logic       w_mem_stall;
   logic       w_load_use;
   logic       w_is_branch;
   logic       w_is_lu;

   // A request without ready is the only thing that freezes the pipe.
   // No request never stalls, whatever the ready line does.
   assign w_mem_stall = dmem_req & ~dmem_ready;

   assign w_load_use = ex_memread & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= c_RUN;
         r_wait_cnt <= 8'd0;
         r_lu_done  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_lu_done  <= w_lu_done_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      case (r_state)
         c_RUN: begin
            if (w_mem_stall) begin
               w_state_nxt    = c_MEM_WAIT;
               w_wait_cnt_nxt = 8'd1;
            end else begin
               w_wait_cnt_nxt = 8'd0;
            end
         end
         c_MEM_WAIT: begin
            if (w_mem_stall) begin
               // The counter already holds the number of waited cycles.
               // Reaching the limit while still unready gives up.
               if (r_wait_cnt == c_WAIT_MAX) begin
                  w_state_nxt = c_HALT;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + 8'd1;
               end
            end else begin
               w_state_nxt    = c_RUN;
               w_wait_cnt_nxt = 8'd0;
            end
         end
         c_HALT: begin
            w_state_nxt = c_HALT;
         end
         default: begin
            w_state_nxt    = c_RUN;
            w_wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      w_is_branch = 1'b0;
      w_is_lu     = 1'b0;

      // While reset is held, the outputs stay at the normal values
      // whatever the hazard inputs show.
      if (!reset) begin
         pc_write = 1'b1;
      end else if ((r_state == c_HALT) || w_mem_stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         memwb_write = 1'b0;
      end else if (mem_branch_taken) begin
         // The wrong-path instructions in IF/ID/EX are squashed. Their
         // registers keep loading, so each bubble is actually captured.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         w_is_branch = 1'b1;
      end else if (w_load_use && !r_lu_done) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
         w_is_lu     = 1'b1;
      end
   end

   // Keep the mask while the pipe is frozen by memory. The bubble is still
   // in EX then. Any other non-stall cycle moves it on, so clear the mask.
   always_comb begin
      if (w_is_lu) begin
         w_lu_done_nxt = 1'b1;
      end else if (w_mem_stall) begin
         w_lu_done_nxt = r_lu_done;
      end else begin
         w_lu_done_nxt = 1'b0;
      end
   end

   assign halted = (r_state == c_HALT);
   assign state  = r_state;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_events;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (!pc_write && (r_state != c_HALT) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
         end
         if (w_is_branch && (r_flush_events != '1)) begin
            r_flush_events <= r_flush_events + 1'b1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule
`default_nettype wire
